// File: rtl/mem_to_bram_arb_if.sv
// Bundle of the load, store and BRAM signals used by mem_to_bram_arb.
// All multi-channel fields are packed, with channel i at bits [(i+1)*W-1 : i*W].
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters and the BRAM model.
interface mem_to_bram_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LOAD   = 2,
  parameter int NUM_STORE  = 1
);
  // load channels
  logic [NUM_LOAD*ADDR_WIDTH-1:0]  loadAddr;
  logic [NUM_LOAD-1:0]             loadEn;
  logic [NUM_LOAD-1:0]             loadReady;
  logic [NUM_LOAD*DATA_WIDTH-1:0]  loadData;
  logic [NUM_LOAD-1:0]             loadDataValid;
  logic [NUM_LOAD-1:0]             loadDataReady;
  // store channels
  logic [NUM_STORE*ADDR_WIDTH-1:0] storeAddr;
  logic [NUM_STORE*DATA_WIDTH-1:0] storeData;
  logic [NUM_STORE-1:0]            storeEn;
  logic [NUM_STORE-1:0]            storeReady;
  // BRAM port 0 (loads)
  logic                            ce0;
  logic                            we0;
  logic [ADDR_WIDTH-1:0]           address0;
  logic [DATA_WIDTH-1:0]           dout0;
  logic [DATA_WIDTH-1:0]           din0;
  // BRAM port 1 (stores)
  logic                            ce1;
  logic                            we1;
  logic [ADDR_WIDTH-1:0]           address1;
  logic [DATA_WIDTH-1:0]           dout1;
  logic [DATA_WIDTH-1:0]           din1;
  // status
  logic                            idle;

  modport slave (
    input  loadAddr, loadEn, loadDataReady,
    input  storeAddr, storeData, storeEn,
    input  din0, din1,
    output loadReady, loadData, loadDataValid,
    output storeReady,
    output ce0, we0, address0, dout0,
    output ce1, we1, address1, dout1,
    output idle
  );

  modport master (
    output loadAddr, loadEn, loadDataReady,
    output storeAddr, storeData, storeEn,
    output din0, din1,
    input  loadReady, loadData, loadDataValid,
    input  storeReady,
    input  ce0, we0, address0, dout0,
    input  ce1, we1, address1, dout1,
    input  idle
  );
endinterface

// File: rtl/mem_to_bram_arb.sv
// Arbiter that connects several load and store channels to a dual-port BRAM.
// Port 0 serves loads and port 1 serves stores. Each port has its own round-robin
// pointer. A load response becomes valid 2 cycles after the grant.
// The optional macro MEM_TO_BRAM_ARB_FWD_EN enables same-cycle store-to-load
// forwarding. In that case the load returns the store data in place of din0.
module mem_to_bram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LOAD   = 2,
  parameter int NUM_STORE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_to_bram_arb_if.slave     bus
);

  localparam int LP_W = (NUM_LOAD  > 1) ? $clog2(NUM_LOAD)  : 1;
  localparam int SP_W = (NUM_STORE > 1) ? $clog2(NUM_STORE) : 1;

  // round-robin pointers
  logic [LP_W-1:0]       r_lp;
  logic [SP_W-1:0]       r_sp;
  // the single load stage between issue and response capture
  logic                  r_s1_vld;
  logic [LP_W-1:0]       r_s1_ch;
  // response registers
  logic [NUM_LOAD-1:0]   r_valid;
  logic [DATA_WIDTH-1:0] r_data [NUM_LOAD];
  logic [ADDR_WIDTH-1:0] r_addr0;

  logic                  w_ld_gnt;
  logic [LP_W-1:0]       w_ld_idx;
  logic [LP_W-1:0]       w_lp_next;
  logic [NUM_LOAD-1:0]   w_ld_elig;
  logic [NUM_LOAD-1:0]   w_inflight;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic                  w_st_gnt;
  logic [SP_W-1:0]       w_st_idx;
  logic [SP_W-1:0]       w_sp_next;
  logic [ADDR_WIDTH-1:0] w_st_addr;
  logic [DATA_WIDTH-1:0] w_st_data;
  logic [DATA_WIDTH-1:0] w_resp;
  logic                  w_unused_din1;

  assign w_unused_din1 = ^bus.din1;

  // A channel is eligible when it requests and has nothing in flight or pending
  always_comb begin
    w_inflight = '0;
    if (r_s1_vld) w_inflight[r_s1_ch] = 1'b1;
    w_ld_elig = bus.loadEn & ~w_inflight & ~r_valid;
  end

  // Round-robin load search starting at r_lp; reset masks every grant
  always_comb begin
    logic [LP_W:0] v_sum;
    logic [LP_W:0] v_nxt;
    w_ld_gnt  = 1'b0;
    w_ld_idx  = '0;
    w_lp_next = r_lp;
    v_sum     = '0;
    v_nxt     = '0;
    for (int k = 0; k < NUM_LOAD; k++) begin
      v_sum = {1'b0, r_lp} + (LP_W+1)'(k);
      if (v_sum >= (LP_W+1)'(NUM_LOAD)) v_sum = v_sum - (LP_W+1)'(NUM_LOAD);
      if (!w_ld_gnt && w_ld_elig[v_sum[LP_W-1:0]]) begin
        w_ld_gnt = 1'b1;
        w_ld_idx = v_sum[LP_W-1:0];
      end
    end
    if (rst) w_ld_gnt = 1'b0;
    v_nxt = {1'b0, w_ld_idx} + (LP_W+1)'(1);
    if (v_nxt == (LP_W+1)'(NUM_LOAD)) v_nxt = '0;
    if (w_ld_gnt) w_lp_next = v_nxt[LP_W-1:0];
  end

  // Round-robin store search starting at r_sp; reset masks every grant
  always_comb begin
    logic [SP_W:0] v_sum;
    logic [SP_W:0] v_nxt;
    w_st_gnt  = 1'b0;
    w_st_idx  = '0;
    w_sp_next = r_sp;
    v_sum     = '0;
    v_nxt     = '0;
    for (int k = 0; k < NUM_STORE; k++) begin
      v_sum = {1'b0, r_sp} + (SP_W+1)'(k);
      if (v_sum >= (SP_W+1)'(NUM_STORE)) v_sum = v_sum - (SP_W+1)'(NUM_STORE);
      if (!w_st_gnt && bus.storeEn[v_sum[SP_W-1:0]]) begin
        w_st_gnt = 1'b1;
        w_st_idx = v_sum[SP_W-1:0];
      end
    end
    if (rst) w_st_gnt = 1'b0;
    v_nxt = {1'b0, w_st_idx} + (SP_W+1)'(1);
    if (v_nxt == (SP_W+1)'(NUM_STORE)) v_nxt = '0;
    if (w_st_gnt) w_sp_next = v_nxt[SP_W-1:0];
  end

  assign w_ld_addr = bus.loadAddr[w_ld_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_st_addr = bus.storeAddr[w_st_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_st_data = bus.storeData[w_st_idx*DATA_WIDTH +: DATA_WIDTH];

  // One-hot ready strobes for the granted load and store channels
  always_comb begin
    bus.loadReady  = '0;
    bus.storeReady = '0;
    if (w_ld_gnt) bus.loadReady[w_ld_idx]  = 1'b1;
    if (w_st_gnt) bus.storeReady[w_st_idx] = 1'b1;
  end

  // Port 0 is read-only. address0 keeps the last issued address while idle.
  assign bus.ce0      = w_ld_gnt;
  assign bus.we0      = 1'b0;
  assign bus.dout0    = '0;
  assign bus.address0 = w_ld_gnt ? w_ld_addr : r_addr0;

  // Port 1 is write-only
  assign bus.ce1      = w_st_gnt;
  assign bus.we1      = w_st_gnt;
  assign bus.address1 = w_st_gnt ? w_st_addr : '0;
  assign bus.dout1    = w_st_gnt ? w_st_data : '0;

`ifdef MEM_TO_BRAM_ARB_FWD_EN
  logic                  r_fwd_hit;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic                  w_fwd_hit;

  assign w_fwd_hit = w_ld_gnt && w_st_gnt && (w_ld_addr == w_st_addr);

  // Record the store data that aliases this cycle's load, for use at capture time
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_hit  <= w_fwd_hit;
      r_fwd_data <= w_st_data;
    end
  end

  assign w_resp = r_fwd_hit ? r_fwd_data : bus.din0;
`else
  assign w_resp = bus.din0;
`endif

  // Pointers, the issue stage and the response registers
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // here sees the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lp     <= '0;
      r_sp     <= '0;
      r_s1_vld <= 1'b0;
      r_s1_ch  <= '0;
      r_valid  <= '0;
      r_addr0  <= '0;
      // NOTE: the response registers are small flops, not a RAM. Clearing them
      // on reset makes loadData read 0 after reset.
      for (int i = 0; i < NUM_LOAD; i++) r_data[i] <= '0;
    end else begin
      r_lp     <= w_lp_next;
      r_sp     <= w_sp_next;
      r_s1_vld <= w_ld_gnt;
      r_s1_ch  <= w_ld_idx;
      if (w_ld_gnt) r_addr0 <= w_ld_addr;
      for (int i = 0; i < NUM_LOAD; i++)
        if (r_valid[i] && bus.loadDataReady[i]) r_valid[i] <= 1'b0;
      // The in-flight channel can never already be valid, so this never
      // collides with the clear above.
      if (r_s1_vld) begin
        r_valid[r_s1_ch] <= 1'b1;
        r_data[r_s1_ch]  <= w_resp;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_LOAD; gi++) begin : g_ld_out
    assign bus.loadData[gi*DATA_WIDTH +: DATA_WIDTH] = r_data[gi];
  end

  assign bus.loadDataValid = r_valid;
  assign bus.idle          = !r_s1_vld && (r_valid == '0);

endmodule

// File: tb/tb_mem_to_bram_arb.sv
// Directed bench for mem_to_bram_arb with the default parameters.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, well away
// from the rising edge.
module tb_mem_to_bram_arb;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NL = 2;
  localparam int NS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  mem_to_bram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LOAD(NL), .NUM_STORE(NS)) bus ();

  mem_to_bram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LOAD(NL), .NUM_STORE(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.loadAddr      = '0;
    bus.loadEn        = '0;
    bus.loadDataReady = '0;
    bus.storeAddr     = '0;
    bus.storeData     = '0;
    bus.storeEn       = '0;
    bus.din0          = '0;
    bus.din1          = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clear_inputs();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_gnt [6];
    int         grants;
    int         stable_bad;
    exp_gnt = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};

    // While rst is high, every ready, ce and we output stays low even with requests pending
    clear_inputs();
    cyc();
    rst = 1'b1;
    bus.loadEn  = 2'b11;
    bus.storeEn = 1'b1;
    #1;
    check("rst_loadReady",  64'(bus.loadReady),  64'h0);
    check("rst_storeReady", 64'(bus.storeReady), 64'h0);
    check("rst_ce0",        64'(bus.ce0),        64'h0);
    check("rst_ce1",        64'(bus.ce1),        64'h0);
    check("rst_we1",        64'(bus.we1),        64'h0);
    cyc();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("post_rst_idle",     64'(bus.idle),          64'h1);
    check("post_rst_valid",    64'(bus.loadDataValid), 64'h0);
    check("post_rst_address0", 64'(bus.address0),      64'h0);
    check("post_rst_loadData", 64'(bus.loadData),      64'h0);

    // Single load: ch0 reads 0x10 and the BRAM returns 0xCAFE
    cyc();
    bus.loadEn   = 2'b01;
    bus.loadAddr = {32'h0, 32'h10};
    bus.din0     = 32'hCAFE;
    #1;
    check("ld_ready",    64'(bus.loadReady), 64'h1);
    check("ld_ce0",      64'(bus.ce0),       64'h1);
    check("ld_address0", 64'(bus.address0),  64'h10);
    check("ld_we0",      64'(bus.we0),       64'h0);
    check("ld_dout0",    64'(bus.dout0),     64'h0);
    cyc();
    bus.loadEn = 2'b00;
    #1;
    check("ld_c1_valid", 64'(bus.loadDataValid), 64'h0);
    check("ld_c1_idle",  64'(bus.idle),          64'h0);
    check("ld_c1_ce0",   64'(bus.ce0),           64'h0);
    check("ld_c1_addr0", 64'(bus.address0),      64'h10);
    cyc();
    bus.loadDataReady = 2'b01;
    #1;
    check("ld_c2_valid", 64'(bus.loadDataValid), 64'h1);
    check("ld_c2_data",  64'(bus.loadData[31:0]), 64'hCAFE);
    cyc();
    bus.loadDataReady = 2'b00;
    #1;
    check("ld_c3_valid", 64'(bus.loadDataValid), 64'h0);
    check("ld_c3_idle",  64'(bus.idle),          64'h1);

    // Round-robin: both channels request continuously and responses are consumed at once
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.loadEn        = 2'b11;
      bus.loadAddr      = {32'h200, 32'h100};
      bus.loadDataReady = 2'b11;
      bus.din0          = 32'h100 + 32'(c);
      #1;
      check($sformatf("rr_gnt_c%0d", c), 64'(bus.loadReady), 64'(exp_gnt[c]));
      if (c == 2) check("rr_ch0_data", 64'(bus.loadData[31:0]),  64'h101);
      if (c == 3) check("rr_ch1_data", 64'(bus.loadData[63:32]), 64'h102);
      cyc();
    end
    bus.loadEn = 2'b00;
    repeat (3) cyc();

    // Backpressure: ch0 keeps requesting while its response is held for 10 cycles
    grants     = 0;
    stable_bad = 0;
    for (int c = 0; c < 12; c++) begin
      bus.loadEn        = 2'b01;
      bus.loadDataReady = (c >= 10) ? 2'b01 : 2'b00;
      bus.din0          = (c <= 1) ? 32'hBEEF : 32'h1234;
      #1;
      if (c <= 10) grants += int'(bus.loadReady[0]);
      if (c >= 2 && c <= 10)
        if (bus.loadDataValid[0] !== 1'b1 || bus.loadData[31:0] !== 32'hBEEF) stable_bad++;
      if (c == 11) begin
        check("bp_regrant",   64'(bus.loadReady),     64'h1);
        check("bp_cleared",   64'(bus.loadDataValid), 64'h0);
      end
      cyc();
    end
    check("bp_one_grant", 64'(grants),     64'd1);
    check("bp_stable",    64'(stable_bad), 64'd0);
    bus.loadEn        = 2'b00;
    bus.loadDataReady = 2'b01;
    repeat (3) cyc();
    bus.loadDataReady = 2'b00;

    // Store: ch0 writes 0x55 to 0x20 in the same cycle
    bus.storeEn   = 1'b1;
    bus.storeAddr = 32'h20;
    bus.storeData = 32'h55;
    #1;
    check("st_ce1",      64'(bus.ce1),        64'h1);
    check("st_we1",      64'(bus.we1),        64'h1);
    check("st_address1", 64'(bus.address1),   64'h20);
    check("st_dout1",    64'(bus.dout1),      64'h55);
    check("st_ready",    64'(bus.storeReady), 64'h1);
    cyc();
    bus.storeEn = 1'b0;
    #1;
    check("st_idle_ce1",   64'(bus.ce1),        64'h0);
    check("st_idle_we1",   64'(bus.we1),        64'h0);
    check("st_idle_ready", 64'(bus.storeReady), 64'h0);

    // Forwarding: a load and a store hit 0x30 in the same cycle while din0 reads 0
    cyc();
    bus.loadEn    = 2'b01;
    bus.loadAddr  = {32'h0, 32'h30};
    bus.storeEn   = 1'b1;
    bus.storeAddr = 32'h30;
    bus.storeData = 32'h77;
    bus.din0      = 32'h0;
    #1;
    check("fwd_ce0",   64'(bus.ce0),      64'h1);
    check("fwd_ce1",   64'(bus.ce1),      64'h1);
    check("fwd_addr0", 64'(bus.address0), 64'h30);
    cyc();
    bus.loadEn  = 2'b00;
    bus.storeEn = 1'b0;
    cyc();
    bus.loadDataReady = 2'b01;
    #1;
    check("fwd_valid", 64'(bus.loadDataValid), 64'h1);
`ifdef MEM_TO_BRAM_ARB_FWD_EN
    check("fwd_data", 64'(bus.loadData[31:0]), 64'h77);
`else
    check("fwd_data", 64'(bus.loadData[31:0]), 64'h0);
`endif
    cyc();
    bus.loadDataReady = 2'b00;

    // Reset arrives the cycle after a grant: the in-flight load must vanish
    cyc();
    bus.loadEn   = 2'b10;
    bus.loadAddr = {32'h44, 32'h0};
    #1;
    check("mr_grant", 64'(bus.loadReady), 64'h2);
    cyc();
    bus.loadEn = 2'b00;
    rst        = 1'b1;
    #1;
    check("mr_rst_ce0", 64'(bus.ce0), 64'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("mr_idle", 64'(bus.idle), 64'h1);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("mr_novalid_c%0d", c), 64'(bus.loadDataValid), 64'h0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
